// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage definitions: PC width, return stack depth,
// PC mux select encodings and the return-stack operation decode.
package cpu_pkg;

  localparam int PC_W      = 12;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  // Bit order is {push, pop}, so the encoding doubles as the strobe pair.
  typedef enum logic [1:0] {
    RAS_IDLE    = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSH    = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic push, input logic pop,
                                         input logic stall);
    return ras_op_e'({push & ~stall, pop & ~stall});
  endfunction

endpackage

// File: rtl/ras_mem.sv
// Storage for the return-stack entries below the top: one synchronous write
// port, one asynchronous read port, no reset.
module ras_mem
  import cpu_pkg::*;
#(
  parameter  int ADDR_W = PC_W,
  parameter  int DEPTH  = RAS_DEPTH,
  localparam int SP_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [SP_W-1:0]   wr_ptr_i,
  input  logic [ADDR_W-1:0] wr_data_i,
  input  logic [SP_W-1:0]   rd_ptr_i,
  output logic [ADDR_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware subroutine-return stack. The top entry lives in its own register
// so top_addr is available to the PC mux in the same cycle a RET decodes.
module return_addr_stack
  import cpu_pkg::*;
#(
  parameter  int ADDR_W = PC_W,
  parameter  int DEPTH  = RAS_DEPTH,
  localparam int SP_W   = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              stall,
  input  logic              clear_err,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] top_q, top_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              empty_w, full_w;
  logic              mem_we;
  logic [SP_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_data;
  ras_op_e           op;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);
  assign op      = ras_decode(push, pop, stall);

  // sp counts the entries held below the top, so the next entry down is sp-1.
  assign rd_ptr = (sp_q == '0) ? '0 : sp_q - SP_W'(1);

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .wr_ptr_i  (sp_q),
    .wr_data_i (top_q),
    .rd_ptr_i  (rd_ptr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    top_d   = top_q;
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;
    mem_we  = 1'b0;

    unique case (op)
      RAS_PUSH: begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          top_d   = push_addr;
          count_d = count_q + CNT_W'(1);
          // An empty stack has no old top worth spilling into the array.
          if (!empty_w) begin
            mem_we = 1'b1;
            sp_d   = sp_q + SP_W'(1);
          end
        end
      end
      RAS_POP: begin
        if (empty_w) begin
          unf_d = 1'b1;
        end else if (count_q == CNT_W'(1)) begin
          top_d   = '0;
          count_d = '0;
        end else begin
          top_d   = rd_data;
          sp_d    = rd_ptr;
          count_d = count_q - CNT_W'(1);
        end
      end
      RAS_REPLACE: begin
        top_d = push_addr;
        if (empty_w) begin
          count_d = CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_addr  = top_q;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: a queue-based stack model produces
// the expected state after each edge, which is queued and compared later.
module tb_return_addr_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] top;
    logic [CNT_W-1:0]  cnt;
    logic              emp;
    logic              ful;
    logic              ovf;
    logic              unf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              stall = 1'b0;
  logic              clear_err = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  int unsigned stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  return_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .stall     (stall),
    .clear_err (clear_err),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".top"},   32'(top_addr),  32'(e.top));
    chk({tag, ".count"}, 32'(count),     32'(e.cnt));
    chk({tag, ".empty"}, 32'(empty),     32'(e.emp));
    chk({tag, ".full"},  32'(full),      32'(e.ful));
    chk({tag, ".ovf"},   32'(overflow),  32'(e.ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(e.unf));
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.top = (stk.size() == 0) ? '0 : ADDR_W'(stk[stk.size()-1]);
    e.cnt = CNT_W'(stk.size());
    e.emp = (stk.size() == 0);
    e.ful = (stk.size() == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  function automatic exp_t reset_state();
    exp_t e;
    e = '0;
    e.emp = 1'b1;
    return e;
  endfunction

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input string tag, input logic p, input logic q, input logic s,
                      input logic c, input logic [ADDR_W-1:0] a);
    logic dp, dq;
    exp_t e;
    @(negedge clk);
    push = p; pop = q; stall = s; clear_err = c; push_addr = a;
    dp = p & ~s;
    dq = q & ~s;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (dp && dq) begin
      if (stk.size() == 0) stk.push_back(32'(a));
      else stk[stk.size()-1] = 32'(a);
    end else if (dp) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(32'(a));
    end else if (dq) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else void'(stk.pop_back());
    end
    sb.push_back(model_state());
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; stall = 1'b0; clear_err = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with strobes active: nothing may change.
    push = 1'b1; pop = 1'b0; push_addr = 12'h055;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", reset_state());
    @(negedge clk);
    push = 1'b0;
    reset = 1'b1;

    // Nested calls and returns.
    step("push10", 1, 0, 0, 0, 12'h010);
    step("push20", 1, 0, 0, 0, 12'h020);
    step("push30", 1, 0, 0, 0, 12'h030);
    step("pop1",   0, 1, 0, 0, 12'h000);
    step("pop2",   0, 1, 0, 0, 12'h000);
    step("pop3",   0, 1, 0, 0, 12'h000);

    // Fill to DEPTH, push once more, then drain.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, ADDR_W'(12'h100 + i));
    step("ovf_push", 1, 0, 0, 0, 12'h1FF);
    chk("ovf_top_const", 32'(top_addr), 32'h107);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 0, 12'h000);

    // Underflow and sticky clearing.
    step("unf_pop",   0, 1, 0, 0, 12'h000);
    step("clr",       0, 0, 0, 1, 12'h000);
    step("unf_pop2",  0, 1, 0, 0, 12'h000);
    step("clr_set",   0, 1, 0, 1, 12'h000);
    step("clr2",      0, 0, 0, 1, 12'h000);

    // Replace-top on a populated and on an empty stack.
    step("rp_push11", 1, 0, 0, 0, 12'h011);
    step("rp_push22", 1, 0, 0, 0, 12'h022);
    step("replace",   1, 1, 0, 0, 12'h033);
    step("rp_pop1",   0, 1, 0, 0, 12'h000);
    step("rp_pop2",   0, 1, 0, 0, 12'h000);
    step("rp_empty",  1, 1, 0, 0, 12'h033);
    step("rp_pop3",   0, 1, 0, 0, 12'h000);

    // Stalled strobes are ignored.
    step("stall_push", 1, 0, 1, 0, 12'h0EE);
    step("sp_push",    1, 0, 0, 0, 12'h0A1);
    step("stall_pop",  0, 1, 1, 0, 12'h000);
    step("stall_rp",   1, 1, 1, 0, 12'h0BB);

    // Asynchronous reset in the middle of a cycle.
    step("ar_push2", 1, 0, 0, 0, 12'h0A2);
    step("ar_push3", 1, 0, 0, 0, 12'h0A3);
    step("ar_ovf",   0, 1, 0, 0, 12'h000);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", reset_state());
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rst_held_edge", reset_state());
    @(negedge clk);
    reset = 1'b1;
    step("post_rst_push", 1, 0, 0, 0, 12'h0AA);
    step("post_rst_pop",  0, 1, 0, 0, 12'h000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

- Hardware subroutine-return stack.
- It responds to the `push`/`pop` strobes that the controller raises for JSB and RET.
  - On JSB it stores the return PC.
  - It always presents the current top entry, so the PC mux can select it in the same cycle a RET is decoded.
- It sits beside the PC register in the fetch stage.
- It reports occupancy and sticky overflow/underflow errors for debug.

## Interface

Parameters:
- `ADDR_W`, default 12: PC/return-address width.
- `DEPTH`, default 8: number of entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low. `reset = 0` clears all state immediately.
- `push`  in  1: store `push_addr` (JSB).
- `pop`  in  1: discard the top entry (RET).
- `stall`  in  1: pipeline stall. While high, `push` and `pop` are ignored.
- `clear_err`  in  1: clears the sticky error flags.
- `push_addr`  in  ADDR_W: return address to store (PC+1 of the JSB).
- `top_addr`  out  ADDR_W: current top-of-stack. Reads 0 when the stack is empty.
- `count`  out  $clog2(DEPTH)+1: number of valid entries, range 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky. Set by a push while full.
- `underflow`  out  1: sticky. Set by a pop while empty.

## Operation

Effective strobes: `do_push = push & ~stall`, `do_pop = pop & ~stall`.

Per rising edge, by case:
- **do_push only, not full:** the old top moves down into the storage array; `top_addr <= push_addr`; `count` +1.
- **do_push only, full:** the push is dropped; state unchanged; `overflow <= 1`.
- **do_pop only, count > 1:** `top_addr <=` the entry below the top; `count` −1.
- **do_pop only, count == 1:** `top_addr <= 0`; `count <= 0`.
- **do_pop only, empty:** state unchanged; `underflow <= 1`.
- **do_push & do_pop together:**
  - Treated as replace-top: `top_addr <= push_addr`; `count` unchanged.
  - If the stack is empty, this acts as a push: `count <= 1`, and `underflow` is not set.
  - No overflow is possible in this case.
- **clear_err:**
  - Clears `overflow` and `underflow` at the edge.
  - If a new error event occurs in the same cycle, set wins.

Storage organisation:
- The top entry is held in a dedicated register, so `top_addr` is a direct register output with no read-port latency.
- The remaining DEPTH−1 entries are held in an array indexed by a pointer `sp`.
- `sp` never wraps:
  - It saturates by rule, because full/empty block further pushes/pops.
  - Pointer arithmetic is unsigned, `$clog2(DEPTH)` bits wide.

Reset values, applied asynchronously when `reset` goes low:
- `top_addr = 0`, `count = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `underflow = 0`.
- Array contents are don't-care.
- Reset asserted mid-sequence discards all entries. The first edge after `reset` returns high behaves as an edge on an empty stack.

## Timing

- Write latency is 1 cycle: a push at edge k gives `top_addr = push_addr` after edge k, and a pop/RET in cycle k+1 returns it.
- Pop latency is 1 cycle: after the edge, `top_addr` shows the new top.
  - The controller uses `top_addr` combinationally during the RET cycle itself, i.e. before the pop edge.
- `empty`, `full` and `count` are registered and consistent with `top_addr` after every edge.
- `stall` is sampled at the same edge as the strobes.
  - A stalled strobe has no effect.
  - The controller holds the strobe until the stall is released.
- Outputs have no combinational path from `push`, `pop` or `push_addr`.

## Structure

- Shared package `cpu_pkg` holds:
  - `PC_W = 12`;
  - the default `RAS_DEPTH = 8`;
  - the pc_mux encodings `PC_NEXT=2'b00`, `PC_BRANCH=2'b01`, `PC_JUMP=2'b10`, `PC_RET=2'b11`.
- One sub-module: `ras_mem`.
  - DEPTH−1 × ADDR_W register array.
  - One synchronous write port and one asynchronous read port, both addressed from `sp`.
  - No reset on the array.
- The top register, pointer, count and flags live in `return_addr_stack`.

## Test plan

1. **Reset:** hold `reset=0`, toggle `clk` → `top_addr=0`, `count=0`, `empty=1`, all flags 0. Strobes applied during reset are ignored.
2. **Nested calls:**
   - Push 0x010, 0x020, 0x030 on consecutive edges → `top_addr` = 0x010, 0x020, 0x030 and `count` = 1, 2, 3.
   - Then three pops → `top_addr` = 0x020, 0x010, 0x000 and `empty=1`.
3. **Overflow (DEPTH=8):**
   - 8 pushes of 0x100..0x107 → `full=1`.
   - 9th push of 0x1FF → `overflow=1`, `top_addr` stays 0x107, `count=8`.
   - 8 pops return 0x106..0x100, then 0.
4. **Underflow and clear:**
   - Pop on empty → `underflow=1`, `count=0`.
   - `clear_err` on the next edge → flag 0.
   - `clear_err` together with another empty pop → flag stays 1.
5. **Replace-top:**
   - With the stack holding [0x011, 0x022], a simultaneous push of 0x033 and pop → `top_addr=0x033`, `count=2`; the next pop gives 0x011.
   - The same on an empty stack → `count=1`, `top_addr=0x033`, no underflow.
6. **Stall and async reset:**
   - Push with `stall=1` → no change.
   - Drop `reset` between edges after 3 pushes → outputs go to reset values immediately, before the next edge.
